// File: rtl/dvi_pkg.sv
// rtl/dvi_pkg.sv - shared DVI widths, TMDS types, control codes and encode helpers
package dvi_pkg;

    localparam int COLOR_W = 8;
    localparam int TMDS_W  = 10;
    localparam int CNT_W   = 5;

    typedef logic [TMDS_W-1:0] tmds_t;

    localparam tmds_t TMDS_CTRL_00 = 10'h354;
    localparam tmds_t TMDS_CTRL_01 = 10'h0AB;
    localparam tmds_t TMDS_CTRL_10 = 10'h154;
    localparam tmds_t TMDS_CTRL_11 = 10'h2AB;

    // Stage-1 pipeline word: transition-minimized data plus delayed controls
    typedef struct packed {
        logic [8:0] q_m;
        logic       display_on;
        logic       c0;
        logic       c1;
    } stage1_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // XOR/XNOR chain chosen to minimize transitions; bit 8 records the choice
    function automatic logic [8:0] tm_encode(input logic [7:0] d);
        logic [3:0] n1d;
        logic       use_xnor;
        logic [8:0] q;
        n1d      = popcount8(d);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic tmds_t ctrl_code(input logic c1, input logic c0);
        tmds_t code;
        case ({c1, c0})
            2'b00:   code = TMDS_CTRL_00;
            2'b01:   code = TMDS_CTRL_01;
            2'b10:   code = TMDS_CTRL_10;
            default: code = TMDS_CTRL_11;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/dvi_tmds_encoder_if.sv
// rtl/dvi_tmds_encoder_if.sv - pixel/control input and TMDS symbol output bundle for one channel
interface dvi_tmds_encoder_if #(
    parameter int COLOR_W = dvi_pkg::COLOR_W
);
    logic                display_on;
    logic [COLOR_W-1:0]  data;
    logic                c0;
    logic                c1;
    dvi_pkg::tmds_t      tmds;

    modport master (output display_on, output data, output c0, output c1, input  tmds);
    modport slave  (input  display_on, input  data, input  c0, input  c1, output tmds);
endinterface

// File: rtl/dvi_tmds_encoder_rgb.sv
// rtl/dvi_tmds_encoder_rgb.sv - three aligned TMDS channels; sync rides on blue
module dvi_tmds_encoder_rgb
    import dvi_pkg::*;
#(
    parameter int COLOR_W = dvi_pkg::COLOR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               display_on,
    input  logic [COLOR_W-1:0] red,
    input  logic [COLOR_W-1:0] green,
    input  logic [COLOR_W-1:0] blue,
    input  logic               hsync,
    input  logic               vsync,
    output tmds_t              tmds_r,
    output tmds_t              tmds_g,
    output tmds_t              tmds_b
);

    dvi_tmds_encoder_if #(.COLOR_W(COLOR_W)) r_if ();
    dvi_tmds_encoder_if #(.COLOR_W(COLOR_W)) g_if ();
    dvi_tmds_encoder_if #(.COLOR_W(COLOR_W)) b_if ();

    assign b_if.display_on = display_on;
    assign b_if.data       = blue;
    assign b_if.c0         = hsync;
    assign b_if.c1         = vsync;

    assign g_if.display_on = display_on;
    assign g_if.data       = green;
    assign g_if.c0         = 1'b0;
    assign g_if.c1         = 1'b0;

    assign r_if.display_on = display_on;
    assign r_if.data       = red;
    assign r_if.c0         = 1'b0;
    assign r_if.c1         = 1'b0;

    assign tmds_b = b_if.tmds;
    assign tmds_g = g_if.tmds;
    assign tmds_r = r_if.tmds;

    dvi_tmds_encoder #(.COLOR_W(COLOR_W)) u_blue  (.clk(clk), .rst(rst), .bus(b_if));
    dvi_tmds_encoder #(.COLOR_W(COLOR_W)) u_green (.clk(clk), .rst(rst), .bus(g_if));
    dvi_tmds_encoder #(.COLOR_W(COLOR_W)) u_red   (.clk(clk), .rst(rst), .bus(r_if));

endmodule

// File: rtl/dvi_tmds_encoder.sv
// rtl/dvi_tmds_encoder.sv - one-channel DVI 1.0 TMDS encoder, 2-stage pipe (3 with DVI_TMDS_ENCODER_REG_OUT_EN)
module dvi_tmds_encoder
    import dvi_pkg::*;
#(
    parameter int COLOR_W = dvi_pkg::COLOR_W
) (
    input  logic              clk,
    input  logic              rst,
    dvi_tmds_encoder_if.slave bus
);

    stage1_t                 s1;
    stage1_t                 s1_next;
    tmds_t                   tmds_s2;
    tmds_t                   tmds_next;
    logic signed [CNT_W-1:0] cnt;
    logic signed [CNT_W-1:0] cnt_next;
    logic signed [CNT_W-1:0] diff;
    logic [3:0]              n1;
    logic [7:0]              q;
    logic                    q8;

    assign q  = s1.q_m[7:0];
    assign q8 = s1.q_m[8];

    // Stage-1 input: transition-minimized word alongside the delayed strobes
    always_comb begin
        s1_next            = '0;
        s1_next.q_m        = tm_encode(bus.data[COLOR_W-1:0]);
        s1_next.display_on = bus.display_on;
        s1_next.c0         = bus.c0;
        s1_next.c1         = bus.c1;
    end

    // Stage-1 register; reset flushes any in-flight symbol
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
        end else begin
            s1 <= s1_next;
        end
    end

    // Stage-2 DC balancing: pick inversion from running disparity; diff = n1 - n0
    always_comb begin
        n1        = popcount8(q);
        diff      = ($signed({1'b0, n1}) - 5'sd4) <<< 1;
        tmds_next = ctrl_code(s1.c1, s1.c0);
        cnt_next  = cnt;
        if (!s1.display_on) begin
            cnt_next = '0;
        end else if ((cnt == 5'sd0) || (diff == 5'sd0)) begin
            tmds_next = {~q8, q8, q8 ? q : ~q};
            cnt_next  = q8 ? (cnt + diff) : (cnt - diff);
        end else if (((cnt > 5'sd0) && (diff > 5'sd0)) || ((cnt < 5'sd0) && (diff < 5'sd0))) begin
            tmds_next = {1'b1, q8, ~q};
            cnt_next  = cnt + (q8 ? 5'sd2 : 5'sd0) - diff;
        end else begin
            tmds_next = {1'b0, q8, q};
            cnt_next  = cnt + diff - (q8 ? 5'sd0 : 5'sd2);
        end
    end

    // Stage-2 register: symbol and running disparity
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmds_s2 <= TMDS_CTRL_00;
            cnt     <= '0;
        end else begin
            tmds_s2 <= tmds_next;
            cnt     <= cnt_next;
        end
    end

`ifdef DVI_TMDS_ENCODER_REG_OUT_EN
    tmds_t tmds_s3;

    // Extra output retiming register, idles at the blank/no-sync code
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmds_s3 <= TMDS_CTRL_00;
        end else begin
            tmds_s3 <= tmds_s2;
        end
    end

    assign bus.tmds = tmds_s3;
`else
    assign bus.tmds = tmds_s2;
`endif

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// tb/tb_dvi_tmds_encoder.sv - scoreboard bench for dvi_tmds_encoder against a DVI 1.0 reference model
module tb_dvi_tmds_encoder;

`ifdef DVI_TMDS_ENCODER_REG_OUT_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        int         due;
        logic [9:0] tmds;
        logic       de;
    } exp_t;

    typedef struct {
        int due;
        int cnt;
    } cnt_exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] tmds_r;
    logic [9:0] tmds_g;
    logic [9:0] tmds_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int m_cnt  = 0;

    exp_t     sq[$];
    cnt_exp_t cq[$];

    dvi_tmds_encoder_if #(.COLOR_W(8)) bus ();

    dvi_tmds_encoder #(.COLOR_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    dvi_tmds_encoder_rgb #(.COLOR_W(8)) u_rgb (
        .clk(clk), .rst(rst), .display_on(bus.display_on),
        .red(bus.data), .green(bus.data), .blue(bus.data),
        .hsync(bus.c0), .vsync(bus.c1),
        .tmds_r(tmds_r), .tmds_g(tmds_g), .tmds_b(tmds_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h (%0d) expected 0x%0h (%0d)", name, cyc, act, act, exp, exp);
        end
    endtask

    // Reference model: DVI 1.0 encoding rules with plain integer disparity
    task automatic model_step(input logic de, input logic [7:0] d, input logic c0, input logic c1,
                              output logic [9:0] t);
        int         n1d, n1, n0, q8;
        logic [7:0] qm;
        logic       xn;
        n1d   = $countones(d);
        xn    = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? !(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        q8 = xn ? 0 : 1;
        if (!de) begin
            case ({c1, c0})
                2'b00:   t = 10'h354;
                2'b01:   t = 10'h0AB;
                2'b10:   t = 10'h154;
                default: t = 10'h2AB;
            endcase
            m_cnt = 0;
        end else begin
            n1 = $countones(qm);
            n0 = 8 - n1;
            if (m_cnt == 0 || n1 == n0) begin
                t     = {q8 == 0, q8 == 1, (q8 == 1) ? qm : ~qm};
                m_cnt = m_cnt + ((q8 == 1) ? (n1 - n0) : (n0 - n1));
            end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
                t     = {1'b1, q8 == 1, ~qm};
                m_cnt = m_cnt + 2 * q8 + (n0 - n1);
            end else begin
                t     = {1'b0, q8 == 1, qm};
                m_cnt = m_cnt + (n1 - n0) - 2 * (1 - q8);
            end
        end
    endtask

    // Drive one input on the falling edge and schedule its expected result
    task automatic drive(input logic de, input logic [7:0] d, input logic c0, input logic c1,
                         input logic use_k, input logic [9:0] k_tmds, input int k_cnt);
        logic [9:0] t;
        @(negedge clk);
        bus.display_on = de;
        bus.data       = d;
        bus.c0         = c0;
        bus.c1         = c1;
        model_step(de, d, c0, c1, t);
        sq.push_back('{due: cyc + LAT, tmds: use_k ? k_tmds : t, de: de});
        cq.push_back('{due: cyc + 2, cnt: use_k ? k_cnt : m_cnt});
    endtask

    task automatic drive_m(input logic de, input logic [7:0] d, input logic c0, input logic c1);
        drive(de, d, c0, c1, 1'b0, 10'h0, 0);
    endtask

    // Asynchronous reset pulse between edges; in-flight symbols are discarded
    task automatic pulse_reset();
        @(negedge clk);
        bus.display_on = 1'b0;
        bus.data       = 8'h00;
        bus.c0         = 1'b0;
        bus.c1         = 1'b0;
        sq.delete();
        cq.delete();
        #2 rst = 1'b1;
        #1;
        check("async_rst_tmds", int'(bus.tmds), 'h354);
        check("async_rst_cnt", int'($signed(dut.cnt)), 0);
        check("async_rst_blue", int'(tmds_b), 'h354);
        #1 rst = 1'b0;
        m_cnt = 0;
    endtask

    // Monitor: pop every due expectation and compare after each rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst) begin
            checks++;
            if ($signed(dut.cnt) > 8 || $signed(dut.cnt) < -8) begin
                errors++;
                $display("FAIL cnt_bound at cycle %0d: got %0d expected within -8..8", cyc, $signed(dut.cnt));
            end
            while (sq.size() > 0 && sq[0].due <= cyc) begin
                exp_t e;
                e = sq.pop_front();
                check("tmds_latency", cyc, e.due);
                check("tmds", int'(bus.tmds), int'(e.tmds));
                check("rgb_blue", int'(tmds_b), int'(e.tmds));
                check("rgb_green", int'(tmds_g), e.de ? int'(e.tmds) : 'h354);
                check("rgb_red", int'(tmds_r), e.de ? int'(e.tmds) : 'h354);
            end
            while (cq.size() > 0 && cq[0].due <= cyc) begin
                cnt_exp_t c;
                c = cq.pop_front();
                check("cnt", int'($signed(dut.cnt)), c.cnt);
            end
        end
    end

    initial begin
        bus.display_on = 1'b0;
        bus.data       = 8'h00;
        bus.c0         = 1'b0;
        bus.c1         = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset_tmds_async", int'(bus.tmds), 'h354);
        check("reset_cnt_async", int'($signed(dut.cnt)), 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_tmds_held", int'(bus.tmds), 'h354);
        check("reset_s1", int'(dut.s1), 0);
        @(negedge clk);
        rst = 1'b0;

        // Control codes, three cycles each
        for (int k = 0; k < 3; k++) drive(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 10'h354, 0);
        for (int k = 0; k < 3; k++) drive(1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 10'h0AB, 0);
        for (int k = 0; k < 3; k++) drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 10'h154, 0);
        for (int k = 0; k < 3; k++) drive(1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 10'h2AB, 0);

        // Run of zeros from cnt = 0 walks the disparity
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 10'h100, -8);
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 10'h3FF, 2);
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 10'h100, -6);
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 10'h3FF, 4);

        // Blanking restarts disparity at 0
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 10'h354, 0);
        drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 10'h200, -8);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 10'h354, 0);
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 10'h100, -8);

        // Mid-line asynchronous reset
        drive_m(1'b1, 8'h3C, 1'b0, 1'b0);
        drive_m(1'b1, 8'hF1, 1'b0, 1'b0);
        pulse_reset();
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 10'h100, -8);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 10'h354, 0);

        // Random traffic against the model
        for (int n = 0; n < 10000; n++) begin
            if (n == 5000) pulse_reset();
            drive_m($urandom_range(0, 9) < 8, 8'($urandom), 1'($urandom), 1'($urandom));
        end

        for (int k = 0; k < LAT + 1; k++) drive_m(1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 20 && (sq.size() > 0 || cq.size() > 0); k++) @(posedge clk);
        #2;
        checks++;
        if (sq.size() > 0 || cq.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0 pending", sq.size() + cq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
